// File: rtl/req_stager.sv
// Request staging and service stage ahead of the 4-way priority selector: latches request
// pulses, offers them to the selector, and then holds each granted client for a fixed service window.
module req_stager #(
    parameter int REQ_W          = 4,
    parameter int SERVICE_CYCLES = 3,
    parameter int CNT_W          = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REQ_W-1:0] req_in,
    input  logic [REQ_W-1:0] cancel_in,
    input  logic [REQ_W-1:0] sel_gnt,
    output logic [REQ_W-1:0] sel_req,
    output logic             sel_en,
    output logic             busy,
    output logic [REQ_W-1:0] serving,
    output logic [REQ_W-1:0] done,
    output logic             protocol_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVICE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [REQ_W-1:0] pend_q, pend_d;
    logic [REQ_W-1:0] serving_q, serving_d;
    logic [REQ_W-1:0] done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             perr_q, perr_d;

    logic             offer;
    logic             gnt_onehot;
    logic             gnt_pending;
    logic             grant_ok;
    logic             last_cycle;
    logic [REQ_W-1:0] retire;

    assign offer       = (state_q == IDLE) && (pend_q != '0);
    assign gnt_onehot  = (sel_gnt != '0) && ((sel_gnt & (sel_gnt - REQ_W'(1))) == '0);
    assign gnt_pending = (sel_gnt & ~pend_q) == '0;
    assign grant_ok    = offer && gnt_onehot && gnt_pending;
    assign last_cycle  = (state_q == SERVE) && (cnt_q == '0);
    assign retire      = last_cycle ? serving_q : '0;

    // Set beats cancel and retire; the client in service is immune to cancel.
    assign pend_d = (pend_q & ~(cancel_in & ~serving_q) & ~retire) | req_in;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        serving_d = serving_q;
        cnt_d     = cnt_q;
        done_d    = '0;
        perr_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    state_d   = SERVE;
                    serving_d = sel_gnt;
                    cnt_d     = CNT_LOAD;
                end else if (offer && (sel_gnt != '0)) begin
                    perr_d = 1'b1;
                end
            end
            SERVE: begin
                if (last_cycle) begin
                    state_d   = IDLE;
                    done_d    = serving_q;
                    serving_d = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            serving_q <= '0;
            done_q    <= '0;
            cnt_q     <= '0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            serving_q <= serving_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            perr_q    <= perr_d;
        end
    end

    assign sel_req      = pend_q;
    assign sel_en       = offer;
    assign busy         = (state_q == SERVE);
    assign serving      = serving_q;
    assign done         = done_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_req_stager.sv
// Directed bench for req_stager: the bench plays a lowest-index selector, with an override for illegal grants,
// and checks every cycle against a client/cycles-left model plus hand-computed pins.
module tb_req_stager;

    localparam int SC = 3;

    logic       clock;
    logic       reset;
    logic [3:0] req_in, cancel_in, sel_gnt;
    logic [3:0] sel_req, serving, done;
    logic       sel_en, busy, protocol_err;

    logic       force_en;
    logic [3:0] force_gnt;

    req_stager #(.REQ_W(4), .SERVICE_CYCLES(SC), .CNT_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_in      (req_in),
        .cancel_in   (cancel_in),
        .sel_gnt     (sel_gnt),
        .sel_req     (sel_req),
        .sel_en      (sel_en),
        .busy        (busy),
        .serving     (serving),
        .done        (done),
        .protocol_err(protocol_err)
    );

    // Selector stand-in: lowest set bit wins, unless the bench forces a grant.
    assign sel_gnt = force_en ? force_gnt : (sel_en ? (sel_req & (~sel_req + 4'd1)) : 4'b0000);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: pending set, client in service (-1 = none), service cycles left.
    logic [3:0] m_pend, m_pend_nx, m_done;
    logic       m_perr;
    int         cur  = -1;
    int         left = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_pend = 4'b0; m_done = 4'b0; m_perr = 1'b0; cur = -1; left = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_pend_nx[i] = m_pend[i];
                if (cancel_in[i] && cur != i) m_pend_nx[i] = 1'b0;
                if (cur == i && left == 1)     m_pend_nx[i] = 1'b0;
                if (req_in[i])                 m_pend_nx[i] = 1'b1;
            end
            m_done = 4'b0;
            m_perr = 1'b0;
            if (cur >= 0) begin
                if (left == 1) begin
                    m_done = 4'(1 << cur);
                    cur    = -1;
                end else begin
                    left = left - 1;
                end
            end else if (m_pend != 4'b0 && sel_gnt != 4'b0) begin
                if ($onehot(sel_gnt) && (sel_gnt & ~m_pend) == 4'b0) begin
                    for (int i = 0; i < 4; i++) if (sel_gnt[i]) cur = i;
                    left = SC;
                end else begin
                    m_perr = 1'b1;
                end
            end
            m_pend = m_pend_nx;
        end
    end

    // Hand-computed pins, keyed by compare-cycle number.
    logic [3:0] lit_sreq [int];
    logic [3:0] lit_serv [int];
    logic [3:0] lit_done [int];
    logic [3:0] lit_perr [int];

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        cyc++;
        check("sel_req", sel_req, m_pend);
        check("sel_en", {3'b0, sel_en}, {3'b0, (cur < 0) && (m_pend != 4'b0)});
        check("busy", {3'b0, busy}, {3'b0, cur >= 0});
        check("serving", serving, (cur >= 0) ? 4'(1 << cur) : 4'b0);
        check("done", done, m_done);
        check("protocol_err", {3'b0, protocol_err}, {3'b0, m_perr});
        if (lit_sreq.exists(cyc)) check("pin_sel_req", sel_req, lit_sreq[cyc]);
        if (lit_serv.exists(cyc)) check("pin_serving", serving, lit_serv[cyc]);
        if (lit_done.exists(cyc)) check("pin_done", done, lit_done[cyc]);
        if (lit_perr.exists(cyc)) check("pin_protocol_err", {3'b0, protocol_err}, lit_perr[cyc]);
    end

    task automatic step(input logic [3:0] r, input logic [3:0] c);
        req_in    = r;
        cancel_in = c;
        @(negedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'b0, 4'b0);
    endtask

    int t0;

    initial begin
        reset = 1'b1; req_in = 4'b0; cancel_in = 4'b0; force_en = 1'b0; force_gnt = 4'b0;
        for (int k = 1; k <= 2; k++) begin
            lit_sreq[k] = 4'b0; lit_serv[k] = 4'b0; lit_done[k] = 4'b0; lit_perr[k] = 4'b0;
        end
        step(4'b1111, 4'b0);
        step(4'b0, 4'b0);
        reset = 1'b0;
        idle(1);

        // 1: single request, mirrored grant
        t0 = cyc;
        lit_sreq[t0+1] = 4'b0100;
        for (int k = 2; k <= 4; k++) lit_serv[t0+k] = 4'b0100;
        lit_done[t0+5] = 4'b0100;
        lit_sreq[t0+5] = 4'b0000;
        lit_serv[t0+5] = 4'b0000;
        step(4'b0100, 4'b0);
        idle(7);

        // 2: three clients served in lowest-index order
        t0 = cyc;
        lit_serv[t0+2] = 4'b0001; lit_done[t0+5]  = 4'b0001;
        lit_serv[t0+6] = 4'b0010; lit_done[t0+9]  = 4'b0010;
        lit_serv[t0+10] = 4'b1000; lit_done[t0+13] = 4'b1000;
        lit_sreq[t0+13] = 4'b0000;
        step(4'b1011, 4'b0);
        idle(15);

        // 3: cancel ignored in service; cancel+request in final cycle keeps it pending
        t0 = cyc;
        lit_sreq[t0+3] = 4'b0001;
        lit_sreq[t0+5] = 4'b0001; lit_done[t0+5] = 4'b0001;
        lit_serv[t0+6] = 4'b0001; lit_done[t0+9] = 4'b0001;
        lit_sreq[t0+9] = 4'b0000;
        step(4'b0001, 4'b0);
        step(4'b0, 4'b0);
        step(4'b0, 4'b0001);
        step(4'b0, 4'b0);
        step(4'b0001, 4'b0001);
        idle(8);

        // 4: cancel of a pending, unserved client
        t0 = cyc;
        lit_sreq[t0+2] = 4'b0011;
        lit_sreq[t0+3] = 4'b0001;
        lit_done[t0+5] = 4'b0001; lit_sreq[t0+5] = 4'b0000;
        lit_serv[t0+6] = 4'b0000; lit_done[t0+9] = 4'b0000;
        step(4'b0011, 4'b0);
        step(4'b0, 4'b0);
        step(4'b0, 4'b0010);
        idle(8);

        // 5: illegal grants: two-hot, then zero (legal wait), then non-pending one-hot
        force_en = 1'b1; force_gnt = 4'b0110;
        t0 = cyc;
        lit_perr[t0+1] = 4'b0000;
        lit_perr[t0+2] = 4'b0001; lit_sreq[t0+2] = 4'b0110; lit_serv[t0+2] = 4'b0000;
        lit_perr[t0+3] = 4'b0000; lit_sreq[t0+3] = 4'b0110; lit_serv[t0+3] = 4'b0000;
        lit_perr[t0+4] = 4'b0001; lit_serv[t0+4] = 4'b0000;
        lit_perr[t0+5] = 4'b0000; lit_serv[t0+5] = 4'b0010; lit_done[t0+8] = 4'b0010;
        lit_serv[t0+9] = 4'b0100; lit_done[t0+12] = 4'b0100;
        step(4'b0110, 4'b0);
        step(4'b0, 4'b0);
        force_gnt = 4'b0000;
        step(4'b0, 4'b0);
        force_gnt = 4'b1000;
        step(4'b0, 4'b0);
        force_en = 1'b0;
        idle(12);

        // 6: reset during the second service cycle, with a request in that cycle
        t0 = cyc;
        lit_serv[t0+3] = 4'b0001;
        lit_serv[t0+4] = 4'b0000; lit_sreq[t0+4] = 4'b0000;
        lit_done[t0+4] = 4'b0000; lit_perr[t0+4] = 4'b0000;
        lit_done[t0+5] = 4'b0000; lit_sreq[t0+5] = 4'b0000;
        step(4'b0001, 4'b0);
        step(4'b0, 4'b0);
        step(4'b0, 4'b0);
        reset = 1'b1;
        step(4'b1000, 4'b0);
        reset = 1'b0;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
